// File: rtl/parking_gate_controller.sv
// Gate sequencer in front of car_parking_system: sensor debounce, one FSM per gate, car_enter/car_leave arbiter.
// Optional build macro PARKING_GATE_STATS_EN adds saturating entries/denials/timeouts counters.
module parking_gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ALLOC_WAIT      = 4,
  parameter int unsigned GATE_TIMEOUT    = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        entry_sensor,
  input  logic        entry_passed,
  input  logic        exit_sensor,
  input  logic        exit_passed,
  input  logic        parking_full,
  input  logic        spot_allocated,
  output logic        car_enter,
  output logic        car_leave,
  output logic        entry_gate_open,
  output logic        exit_gate_open,
`ifdef PARKING_GATE_STATS_EN
  output logic [15:0] entries_total,
  output logic [15:0] denials_total,
  output logic [15:0] timeouts_total,
`endif
  output logic        entry_denied
);

  localparam int unsigned TMR_MAX = (GATE_TIMEOUT > ALLOC_WAIT) ? GATE_TIMEOUT : ALLOC_WAIT;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  typedef logic [TW-1:0] tmr_t;
  localparam tmr_t ALLOC_LAST = tmr_t'(ALLOC_WAIT - 1);
  localparam tmr_t GATE_LAST  = tmr_t'(GATE_TIMEOUT - 1);

  typedef enum logic [2:0] {E_IDLE, E_DEBOUNCE, E_REQ, E_ALLOC, E_OPEN, E_DENY, E_CLEAR} e_state_t;
  typedef enum logic [1:0] {X_IDLE, X_DEBOUNCE, X_OPEN, X_CLEAR} x_state_t;

  e_state_t   e_state_q;
  x_state_t   x_state_q;
  logic [1:0] e_sync_q, x_sync_q;
  logic [3:0] e_cnt_q, x_cnt_q;
  tmr_t       e_tmr_q, x_tmr_q;
  logic       enter_pend_q;
  logic [1:0] leave_pend_q, leave_pend_d;
  logic [2:0] leave_sum;

  logic e_s, x_s, e_acc, x_acc;
  logic e_alloc_exp, e_open_exp, e_refund, x_pass, x_open_exp;
  logic enter_set, issue_enter, issue_leave;

  function automatic logic [3:0] deb_next(input logic s, input logic [3:0] c);
    if (!s) return 4'd0;
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // Acceptance fires on the sample that completes DEBOUNCE_CYCLES consecutive highs.
  assign e_s   = e_sync_q[1];
  assign x_s   = x_sync_q[1];
  assign e_acc = e_s && ((5'(e_cnt_q) + 5'd1) >= 5'(DEBOUNCE_CYCLES));
  assign x_acc = x_s && ((5'(x_cnt_q) + 5'd1) >= 5'(DEBOUNCE_CYCLES));

  assign e_alloc_exp = (e_state_q == E_ALLOC) && !spot_allocated && (e_tmr_q == ALLOC_LAST);
  assign e_open_exp  = (e_state_q == E_OPEN) && !entry_passed && (e_tmr_q == GATE_LAST);
  assign e_refund    = e_alloc_exp | e_open_exp;
  assign x_pass      = (x_state_q == X_OPEN) && exit_passed;
  assign x_open_exp  = (x_state_q == X_OPEN) && !exit_passed && (x_tmr_q == GATE_LAST);

  assign enter_set   = (e_state_q == E_REQ) && !enter_pend_q;
  assign issue_leave = (leave_pend_q != 2'd0);
  assign issue_enter = enter_pend_q && !issue_leave;

  // NOTE: every always_comb output is fully assigned on each pass, so no latch can be inferred.
  always_comb begin
    leave_sum    = {1'b0, leave_pend_q} - {2'b0, issue_leave} + {2'b0, e_refund} + {2'b0, x_pass};
    leave_pend_d = (leave_sum > 3'd3) ? 2'd3 : leave_sum[1:0];
  end

  // NOTE: async active-low reset on every flop; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_sync_q     <= '0;
      x_sync_q     <= '0;
      e_cnt_q      <= '0;
      x_cnt_q      <= '0;
      enter_pend_q <= 1'b0;
      leave_pend_q <= '0;
      car_enter    <= 1'b0;
      car_leave    <= 1'b0;
    end else begin
      e_sync_q     <= {e_sync_q[0], entry_sensor};
      x_sync_q     <= {x_sync_q[0], exit_sensor};
      e_cnt_q      <= deb_next(e_s, e_cnt_q);
      x_cnt_q      <= deb_next(x_s, x_cnt_q);
      enter_pend_q <= enter_set | (enter_pend_q & ~issue_enter);
      leave_pend_q <= leave_pend_d;
      car_enter    <= issue_enter;
      car_leave    <= issue_leave;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_state_q       <= E_IDLE;
      e_tmr_q         <= '0;
      entry_gate_open <= 1'b0;
      entry_denied    <= 1'b0;
    end else begin
      case (e_state_q)
        E_IDLE:     if (e_s) e_state_q <= E_DEBOUNCE;
        E_DEBOUNCE: begin
          if (!e_s) begin
            e_state_q <= E_IDLE;
          end else if (e_acc) begin
            if (parking_full) begin
              e_state_q    <= E_DENY;
              entry_denied <= 1'b1;
            end else begin
              e_state_q <= E_REQ;
            end
          end
        end
        E_REQ: begin
          if (issue_enter) begin
            e_state_q <= E_ALLOC;
            e_tmr_q   <= '0;
          end
        end
        E_ALLOC: begin
          if (spot_allocated) begin
            e_state_q       <= E_OPEN;
            e_tmr_q         <= '0;
            entry_gate_open <= 1'b1;
          end else if (e_alloc_exp) begin
            e_state_q    <= E_DENY;
            entry_denied <= 1'b1;
          end else begin
            e_tmr_q <= e_tmr_q + tmr_t'(1);
          end
        end
        // Sensor level and parking_full are deliberately ignored once the barrier is up.
        E_OPEN: begin
          if (entry_passed || e_open_exp) begin
            e_state_q       <= E_CLEAR;
            entry_gate_open <= 1'b0;
          end else begin
            e_tmr_q <= e_tmr_q + tmr_t'(1);
          end
        end
        E_DENY: begin
          if (!e_s) begin
            e_state_q    <= E_IDLE;
            entry_denied <= 1'b0;
          end
        end
        E_CLEAR:    if (!e_s && !entry_passed) e_state_q <= E_IDLE;
        default: begin
          e_state_q       <= E_IDLE;
          entry_gate_open <= 1'b0;
          entry_denied    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_state_q      <= X_IDLE;
      x_tmr_q        <= '0;
      exit_gate_open <= 1'b0;
    end else begin
      case (x_state_q)
        X_IDLE:     if (x_s) x_state_q <= X_DEBOUNCE;
        X_DEBOUNCE: begin
          if (!x_s) begin
            x_state_q <= X_IDLE;
          end else if (x_acc) begin
            x_state_q      <= X_OPEN;
            x_tmr_q        <= '0;
            exit_gate_open <= 1'b1;
          end
        end
        X_OPEN: begin
          if (exit_passed || x_open_exp) begin
            x_state_q      <= X_CLEAR;
            exit_gate_open <= 1'b0;
          end else begin
            x_tmr_q <= x_tmr_q + tmr_t'(1);
          end
        end
        X_CLEAR:    if (!x_s && !exit_passed) x_state_q <= X_IDLE;
        default: begin
          x_state_q      <= X_IDLE;
          exit_gate_open <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARKING_GATE_STATS_EN
  logic       e_deny_evt, e_entry_evt;
  logic [1:0] tmo_inc;

  assign e_deny_evt  = ((e_state_q == E_DEBOUNCE) && e_acc && parking_full) || e_alloc_exp;
  assign e_entry_evt = (e_state_q == E_OPEN) && entry_passed;
  assign tmo_inc     = {1'b0, e_open_exp} + {1'b0, x_open_exp};

  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entries_total  <= '0;
      denials_total  <= '0;
      timeouts_total <= '0;
    end else begin
      entries_total  <= sat_add(entries_total, {1'b0, e_entry_evt});
      denials_total  <= sat_add(denials_total, {1'b0, e_deny_evt});
      timeouts_total <= sat_add(timeouts_total, tmo_inc);
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed scenarios plus a random soak, all checked against
// a cycle-level behavioural model built from gate phases, absolute deadlines and a pending-leave count.
module tb_parking_gate_controller;
  localparam int DEB = 4;
  localparam int AW  = 4;
  localparam int GT  = 50;

  logic clk = 1'b0;
  logic reset;
  logic entry_sensor, entry_passed, exit_sensor, exit_passed, parking_full, spot_allocated;
  logic car_enter, car_leave, entry_gate_open, exit_gate_open, entry_denied;
`ifdef PARKING_GATE_STATS_EN
  logic [15:0] entries_total, denials_total, timeouts_total;
`endif

  always #5 clk = ~clk;

  parking_gate_controller #(.DEBOUNCE_CYCLES(DEB), .ALLOC_WAIT(AW), .GATE_TIMEOUT(GT)) dut (
    .clk(clk), .reset(reset),
    .entry_sensor(entry_sensor), .entry_passed(entry_passed),
    .exit_sensor(exit_sensor), .exit_passed(exit_passed),
    .parking_full(parking_full), .spot_allocated(spot_allocated),
    .car_enter(car_enter), .car_leave(car_leave),
    .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
`ifdef PARKING_GATE_STATS_EN
    .entries_total(entries_total), .denials_total(denials_total), .timeouts_total(timeouts_total),
`endif
    .entry_denied(entry_denied)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: gate phases with absolute deadlines and a saturating leave backlog.
  localparam int P_IDLE = 0, P_DEB = 1, P_REQ = 2, P_ALLOC = 3, P_OPEN = 4, P_DENY = 5, P_CLEAR = 6;
  int m_cyc, m_es1, m_es2, m_xs1, m_xs2, m_erun, m_xrun;
  int m_eph, m_xph, m_edl, m_xdl, m_epend, m_lcnt, m_enter, m_leave;
  int m_entries, m_denials, m_timeouts;

  // Stimulus knobs and observation tallies.
  int k_esens, k_xsens, k_full, k_spot, k_epass, k_xpass, k_edly, k_xdly, k_rand;
  int e_open_run, x_open_run, ce_cyc;
  int n_enter, n_leave, n_eopen, saw_denied, first_enter, first_leave;

  task automatic model_reset();
    m_cyc = 0; m_es1 = 0; m_es2 = 0; m_xs1 = 0; m_xs2 = 0; m_erun = 0; m_xrun = 0;
    m_eph = P_IDLE; m_xph = P_IDLE; m_edl = 0; m_xdl = 0; m_epend = 0; m_lcnt = 0;
    m_enter = 0; m_leave = 0; m_entries = 0; m_denials = 0; m_timeouts = 0;
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_step();
    int es, xs, lv, en, refund, xleave, ne, nx, newpend;
    bit eacc, xacc;
    es = m_es2; xs = m_xs2;
    eacc = (es != 0) && (m_erun + 1 >= DEB);
    xacc = (xs != 0) && (m_xrun + 1 >= DEB);
    lv = (m_lcnt > 0) ? 1 : 0;
    en = (m_epend != 0 && lv == 0) ? 1 : 0;
    newpend = en ? 0 : m_epend;
    refund = 0; xleave = 0; ne = m_eph; nx = m_xph;
    case (m_eph)
      P_IDLE:  if (es != 0) ne = P_DEB;
      P_DEB: begin
        if (es == 0) ne = P_IDLE;
        else if (eacc) begin
          if (parking_full) begin ne = P_DENY; m_denials = sat16(m_denials + 1); end
          else ne = P_REQ;
        end
      end
      P_REQ: begin
        if (m_epend == 0) newpend = 1;
        else if (en != 0) begin ne = P_ALLOC; m_edl = m_cyc + AW; end
      end
      P_ALLOC: begin
        if (spot_allocated) begin ne = P_OPEN; m_edl = m_cyc + GT; end
        else if (m_cyc == m_edl) begin ne = P_DENY; refund = 1; m_denials = sat16(m_denials + 1); end
      end
      P_OPEN: begin
        if (entry_passed) begin ne = P_CLEAR; m_entries = sat16(m_entries + 1); end
        else if (m_cyc == m_edl) begin ne = P_CLEAR; refund = 1; m_timeouts = sat16(m_timeouts + 1); end
      end
      P_DENY:  if (es == 0) ne = P_IDLE;
      default: if (es == 0 && !entry_passed) ne = P_IDLE;
    endcase
    case (m_xph)
      P_IDLE:  if (xs != 0) nx = P_DEB;
      P_DEB: begin
        if (xs == 0) nx = P_IDLE;
        else if (xacc) begin nx = P_OPEN; m_xdl = m_cyc + GT; end
      end
      P_OPEN: begin
        if (exit_passed) begin nx = P_CLEAR; xleave = 1; end
        else if (m_cyc == m_xdl) begin nx = P_CLEAR; m_timeouts = sat16(m_timeouts + 1); end
      end
      default: if (xs == 0 && !exit_passed) nx = P_IDLE;
    endcase
    m_lcnt  = m_lcnt - lv + refund + xleave;
    if (m_lcnt > 3) m_lcnt = 3;
    m_epend = newpend; m_enter = en; m_leave = lv;
    m_eph = ne; m_xph = nx;
    m_erun = (es != 0) ? ((m_erun < 15) ? m_erun + 1 : 15) : 0;
    m_xrun = (xs != 0) ? ((m_xrun < 15) ? m_xrun + 1 : 15) : 0;
    m_es2 = m_es1; m_es1 = int'(entry_sensor);
    m_xs2 = m_xs1; m_xs1 = int'(exit_sensor);
    m_cyc++;
  endtask

  task automatic check_outputs();
    check("car_enter", car_enter, m_enter);
    check("car_leave", car_leave, m_leave);
    check("pulse_exclusive", car_enter & car_leave, 0);
    check("entry_gate_open", entry_gate_open, (m_eph == P_OPEN) ? 1 : 0);
    check("exit_gate_open", exit_gate_open, (m_xph == P_OPEN) ? 1 : 0);
    check("entry_denied", entry_denied, (m_eph == P_DENY) ? 1 : 0);
`ifdef PARKING_GATE_STATS_EN
    check("entries_total", entries_total, m_entries);
    check("denials_total", denials_total, m_denials);
    check("timeouts_total", timeouts_total, m_timeouts);
`endif
    if (car_enter) begin
      n_enter++; ce_cyc = m_cyc;
      if (first_enter < 0) first_enter = m_cyc;
    end
    if (car_leave) begin
      n_leave++;
      if (first_leave < 0) first_leave = m_cyc;
    end
    if (entry_gate_open) n_eopen++;
    if (entry_denied) saw_denied = 1;
    e_open_run = entry_gate_open ? e_open_run + 1 : 0;
    x_open_run = exit_gate_open ? x_open_run + 1 : 0;
  endtask

  task automatic drive_and_step();
    if (k_rand != 0) begin
      if ($urandom_range(0, 7) == 0) k_esens ^= 1;
      if ($urandom_range(0, 7) == 0) k_xsens ^= 1;
      if ($urandom_range(0, 31) == 0) k_full ^= 1;
    end
    entry_sensor = k_esens[0];
    exit_sensor  = k_xsens[0];
    parking_full = k_full[0];
    case (k_spot)
      1:       spot_allocated = (m_cyc == ce_cyc + 2);
      2:       spot_allocated = ($urandom_range(0, 2) == 0);
      default: spot_allocated = 1'b0;
    endcase
    case (k_epass)
      1:       entry_passed = (e_open_run >= k_edly + 1);
      2:       entry_passed = ($urandom_range(0, 5) == 0);
      default: entry_passed = 1'b0;
    endcase
    case (k_xpass)
      1:       exit_passed = (x_open_run >= k_xdly + 1);
      2:       exit_passed = ($urandom_range(0, 5) == 0);
      default: exit_passed = 1'b0;
    endcase
    model_step();
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    drive_and_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_tallies();
    n_enter = 0; n_leave = 0; n_eopen = 0; saw_denied = 0; first_enter = -1; first_leave = -1;
  endtask

  task automatic quiet_inputs();
    k_esens = 0; k_xsens = 0; k_full = 0; k_spot = 0; k_epass = 0; k_xpass = 0; k_rand = 0;
    entry_sensor = 0; exit_sensor = 0; parking_full = 0; spot_allocated = 0;
    entry_passed = 0; exit_passed = 0;
    e_open_run = 0; x_open_run = 0; ce_cyc = -100;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_car_enter"}, car_enter, 0);
    check({tag, "_car_leave"}, car_leave, 0);
    check({tag, "_entry_open"}, entry_gate_open, 0);
    check({tag, "_exit_open"}, exit_gate_open, 0);
    check({tag, "_denied"}, entry_denied, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive_and_step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    k_edly = 0; k_xdly = 0;
    reset = 1'b0;
    quiet_inputs();
    model_reset();
    clear_tallies();
    #1;
    check_all_zero("reset");
    release_reset();

    // Granted entry with spot two cycles after car_enter; the car passes.
    clear_tallies();
    k_esens = 1; k_spot = 1; k_epass = 1; k_edly = 5;
    run(30);
    k_esens = 0;
    run(10);
    check("t1_enter_count", n_enter, 1);
    check("t1_leave_count", n_leave, 0);
    check("t1_gate_opened", (n_eopen > 0) ? 1 : 0, 1);

    // Lot full: deny, lamp held until the sensor drops.
    quiet_inputs(); clear_tallies();
    k_full = 1; k_esens = 1;
    run(15);
    k_esens = 0;
    run(6);
    check("t2_enter_count", n_enter, 0);
    check("t2_denied_seen", saw_denied, 1);
    check("t2_denied_released", entry_denied, 0);
    check("t2_gate_never_open", n_eopen, 0);

    // No spot allocation: refund leave and denial.
    quiet_inputs(); clear_tallies();
    k_esens = 1;
    run(25);
    check("t3_denied_seen", saw_denied, 1);
    k_esens = 0;
    run(6);
    check("t3_enter_count", n_enter, 1);
    check("t3_refund_count", n_leave, 1);

    // Car never passes: gate open for GATE_TIMEOUT cycles, refund; bounce and lot-full ignored.
    quiet_inputs(); clear_tallies();
    k_esens = 1; k_spot = 1;
    run(30);
    k_esens = 0; tick(); k_esens = 1;
    k_full = 1;
    run(50);
    k_esens = 0; k_full = 0;
    run(8);
    check("t4_enter_count", n_enter, 1);
    check("t4_refund_count", n_leave, 1);
    check("t4_open_cycles", n_eopen, GT);
`ifdef PARKING_GATE_STATS_EN
    check("t4_timeouts_total", timeouts_total, 1);
`endif

    // Both gates accepted together: car_leave first, car_enter after.
    quiet_inputs(); clear_tallies();
    k_esens = 1; k_xsens = 1; k_spot = 1; k_epass = 1; k_edly = 2; k_xpass = 1; k_xdly = 0;
    run(30);
    k_esens = 0; k_xsens = 0;
    run(8);
    check("t5_enter_count", n_enter, 1);
    check("t5_leave_count", n_leave, 1);
    check("t5_leave_first", (first_leave >= 0 && first_enter > first_leave) ? 1 : 0, 1);

    // Bounced sensor, then async reset while the barrier is up.
    quiet_inputs(); clear_tallies();
    k_spot = 1;
    begin
      int pat [6] = '{1, 1, 0, 1, 1, 1};
      for (int i = 0; i < 6; i++) begin
        k_esens = pat[i];
        tick();
      end
    end
    run(2);
    check("t6_no_early_accept", n_enter, 0);
    for (int i = 0; i < 40 && m_eph != P_OPEN; i++) tick();
    @(negedge clk);
    check_outputs();
    check("t6_gate_up_before_reset", entry_gate_open, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    quiet_inputs();
    model_reset();
    release_reset();
    run(5);

    // Random soak against the model.
    quiet_inputs(); clear_tallies();
    k_rand = 1; k_spot = 2; k_epass = 2; k_xpass = 2;
    run(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
